// File: rtl/mat_reg_seq_if.sv
// MatReg op encodings and the command/stream/control bundle
// shared by the sequencer and its environment.
package mat_reg_pkg;
    typedef enum logic [1:0] {
        MAT_DATA_WRITE_DISABLE   = 2'd0,
        MAT_DATA_WRITE_ROW       = 2'd1,
        MAT_DATA_WRITE_COL       = 2'd2,
        MAT_DATA_WRITE_TRANSPOSE = 2'd3
    } MatDataWriteOp_t;

    typedef enum logic [1:0] {
        MAT_DATA_READ_ROW  = 2'd0,
        MAT_DATA_READ_COL  = 2'd1,
        MAT_DATA_READ_DIAG = 2'd2
    } MatDataReadOp_t;

    localparam logic [2:0] OP_LOAD_ROW   = 3'd0;
    localparam logic [2:0] OP_LOAD_COL   = 3'd1;
    localparam logic [2:0] OP_TRANSPOSE  = 3'd2;
    localparam logic [2:0] OP_STORE_ROW  = 3'd3;
    localparam logic [2:0] OP_STORE_COL  = 3'd4;
    localparam logic [2:0] OP_STORE_DIAG = 3'd5;
endpackage

interface mat_reg_seq_if #(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
);
    import mat_reg_pkg::*;

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [2:0]                 cmd_op;
    logic [WIDTH_ADDR_SIZE-1:0] cmd_base;
    logic [WIDTH_ADDR_SIZE:0]   cmd_count;
    logic                       in_valid;
    logic                       in_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    MatDataWriteOp_t            write_op;
    logic [WIDTH_ADDR_SIZE-1:0] write_param1;
    logic [WIDTH_ADDR_SIZE-1:0] write_param2;
    MatDataReadOp_t             read_op;
    logic [WIDTH_ADDR_SIZE-1:0] read_param;
    logic                       busy;
    logic                       done;
    logic                       cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_count,
        output in_valid, out_ready,
        input  cmd_ready, in_ready, out_valid, out_last,
        input  write_op, write_param1, write_param2,
        input  read_op, read_param, busy, done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_count,
        input  in_valid, out_ready,
        output cmd_ready, in_ready, out_valid, out_last,
        output write_op, write_param1, write_param2,
        output read_op, read_param, busy, done, cmd_err
    );
endinterface

// File: rtl/mat_reg_seq.sv
// Expands block commands into per-cycle MatReg write/read ops
// and handshakes the vector streams feeding and draining it.
module mat_reg_seq
    import mat_reg_pkg::*;
#(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
    input logic         clock,
    input logic         reset,
    mat_reg_seq_if.slave bus
);
    localparam int AW = WIDTH_ADDR_SIZE;
    localparam logic [AW:0]   FULL = (AW+1)'(WIDTH);
    localparam logic [AW-1:0] LAST = AW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, XPOSE, STORE, DONE
    } state_t;

    state_t        r_state, w_state;
    logic [AW-1:0] r_idx, w_idx;
    logic [AW:0]   r_rem, w_rem;
    logic [2:0]    r_op, w_op;
    logic          r_err, w_err;

    logic [AW-1:0] w_idx_nxt;
    logic          w_is_load;
    logic          w_is_xpose;
    logic          w_is_store;

    assign w_idx_nxt  = (r_idx == LAST) ? '0 : r_idx + 1'b1;
    assign w_is_load  = (bus.cmd_op == OP_LOAD_ROW) ||
                        (bus.cmd_op == OP_LOAD_COL);
    assign w_is_xpose = (bus.cmd_op == OP_TRANSPOSE);
    assign w_is_store = (bus.cmd_op == OP_STORE_ROW) ||
                        (bus.cmd_op == OP_STORE_COL) ||
                        (bus.cmd_op == OP_STORE_DIAG);
    assign bus.write_param2 = '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_rem   <= '0;
            r_op    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_rem   <= w_rem;
            r_op    <= w_op;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state          = r_state;
        w_idx            = r_idx;
        w_rem            = r_rem;
        w_op             = r_op;
        w_err            = r_err;
        bus.cmd_ready    = 1'b0;
        bus.in_ready     = 1'b0;
        bus.out_valid    = 1'b0;
        bus.out_last     = 1'b0;
        bus.write_op     = MAT_DATA_WRITE_DISABLE;
        bus.write_param1 = '0;
        bus.read_op      = MAT_DATA_READ_ROW;
        bus.read_param   = '0;
        bus.busy         = (r_state != IDLE);
        bus.done         = 1'b0;
        bus.cmd_err      = 1'b0;
        unique case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_idx = bus.cmd_base;
                    w_rem = (bus.cmd_count == '0) ? FULL : bus.cmd_count;
                    w_op  = bus.cmd_op;
                    unique case (1'b1)
                        w_is_load:  w_state = LOAD;
                        w_is_xpose: w_state = XPOSE;
                        w_is_store: w_state = STORE;
                        default: begin
                            w_state = DONE;
                            w_err   = 1'b1;
                        end
                    endcase
                end
            end
            LOAD: begin
                bus.in_ready     = 1'b1;
                bus.write_param1 = r_idx;
                if (bus.in_valid) begin
                    bus.write_op = (r_op == OP_LOAD_COL) ?
                                   MAT_DATA_WRITE_COL : MAT_DATA_WRITE_ROW;
                    w_idx = w_idx_nxt;
                    w_rem = r_rem - 1'b1;
                    if (r_rem == 1) w_state = DONE;
                end
            end
            XPOSE: begin
                bus.write_op = MAT_DATA_WRITE_TRANSPOSE;
                w_state      = DONE;
            end
            STORE: begin
                bus.out_valid  = 1'b1;
                bus.read_param = r_idx;
                bus.out_last   = (r_rem == 1);
                if (r_op == OP_STORE_COL)
                    bus.read_op = MAT_DATA_READ_COL;
                else if (r_op == OP_STORE_DIAG)
                    bus.read_op = MAT_DATA_READ_DIAG;
                if (bus.out_ready) begin
                    w_idx = w_idx_nxt;
                    w_rem = r_rem - 1'b1;
                    if (r_rem == 1) w_state = DONE;
                end
            end
            DONE: begin
                bus.done    = 1'b1;
                bus.cmd_err = r_err;
                w_err       = 1'b0;
                w_state     = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mat_reg_seq.sv
// Directed bench for mat_reg_seq at WIDTH=4 with
// hand-computed per-cycle control expectations.
module tb_mat_reg_seq;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mat_reg_seq_if #(.WIDTH(W)) bus ();

    mat_reg_seq #(.WIDTH(W)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int op, input int base, input int cnt);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'(op);
        bus.cmd_base  = 2'(base);
        bus.cmd_count = 3'(cnt);
        #1;
        chk("cmd_ready", int'(bus.cmd_ready), 1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic chk_done(input string tag, input int err);
        #1;
        chk({tag, "_done"}, int'(bus.done), 1);
        chk({tag, "_err"}, int'(bus.cmd_err), err);
        chk({tag, "_wop"}, int'(bus.write_op), 0);
        chk({tag, "_oval"}, int'(bus.out_valid), 0);
        step();
        #1;
        chk({tag, "_idle_rdy"}, int'(bus.cmd_ready), 1);
        chk({tag, "_idle_done"}, int'(bus.done), 0);
    endtask

    int lr_p[4];
    int lc_v[4];
    int lc_op[4];
    int lc_p[4];
    int sd_r[4];
    int sd_p[4];
    int sd_l[4];

    initial begin
        errors = 0;
        checks = 0;
        lc_v  = '{1, 0, 1, 1};
        lc_op = '{2, 0, 2, 2};
        lc_p  = '{3, 0, 0, 1};
        sd_r  = '{0, 0, 1, 1};
        sd_p  = '{1, 1, 1, 2};
        sd_l  = '{0, 0, 0, 1};
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_base  = '0;
        bus.cmd_count = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_wop", int'(bus.write_op), 0);
        chk("rst_rop", int'(bus.read_op), 0);
        step();
        rst = 1'b0;
        step();

        // LOAD_ROW base 0, count 0 (= 4 beats)
        issue(0, 0, 0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("lr_in_ready", int'(bus.in_ready), 1);
            chk("lr_wop", int'(bus.write_op), 1);
            chk("lr_p1", int'(bus.write_param1), i);
            chk("lr_busy", int'(bus.busy), 1);
            step();
        end
        bus.in_valid = 1'b0;
        chk_done("lr", 0);

        // LOAD_COL base 3, count 3, gapped input with index wrap
        issue(1, 3, 3);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = lc_v[i][0];
            #1;
            chk("lc_wop", int'(bus.write_op), lc_op[i]);
            chk("lc_p1", int'(bus.write_param1), lc_p[i]);
            step();
        end
        bus.in_valid = 1'b0;
        chk_done("lc", 0);

        // STORE_DIAG base 1, count 2 with back-pressure
        issue(5, 1, 2);
        for (int i = 0; i < 4; i++) begin
            bus.out_ready = sd_r[i][0];
            #1;
            chk("sd_oval", int'(bus.out_valid), 1);
            chk("sd_rop", int'(bus.read_op), 2);
            chk("sd_rp", int'(bus.read_param), sd_p[i]);
            chk("sd_last", int'(bus.out_last), sd_l[i]);
            step();
        end
        bus.out_ready = 1'b0;
        #1;
        chk("sd_rop_after", int'(bus.read_op), 0);
        chk("sd_rp_after", int'(bus.read_param), 0);
        chk_done("sd", 0);

        // TRANSPOSE then STORE_ROW of one row
        issue(2, 0, 0);
        #1;
        chk("xp_wop", int'(bus.write_op), 3);
        chk("xp_busy", int'(bus.busy), 1);
        chk("xp_done_early", int'(bus.done), 0);
        step();
        chk_done("xp", 0);
        issue(3, 0, 1);
        bus.out_ready = 1'b1;
        #1;
        chk("sr_rop", int'(bus.read_op), 0);
        chk("sr_rp", int'(bus.read_param), 0);
        chk("sr_last", int'(bus.out_last), 1);
        chk("sr_oval", int'(bus.out_valid), 1);
        step();
        bus.out_ready = 1'b0;
        chk_done("sr", 0);

        // Illegal opcode, then a normal command
        issue(7, 1, 2);
        #1;
        chk("il_inr", int'(bus.in_ready), 0);
        chk_done("il", 1);
        issue(0, 2, 1);
        bus.in_valid = 1'b1;
        #1;
        chk("nx_wop", int'(bus.write_op), 1);
        chk("nx_p1", int'(bus.write_param1), 2);
        step();
        bus.in_valid = 1'b0;
        chk_done("nx", 0);

        // Reset in the middle of a LOAD
        issue(0, 0, 4);
        bus.in_valid = 1'b1;
        step();
        step();
        #1;
        chk("mr_pre_wop", int'(bus.write_op), 1);
        chk("mr_pre_p1", int'(bus.write_param1), 2);
        rst = 1'b1;
        #1;
        chk("mr_wop", int'(bus.write_op), 0);
        chk("mr_inr", int'(bus.in_ready), 0);
        chk("mr_busy", int'(bus.busy), 0);
        chk("mr_cmd_ready", int'(bus.cmd_ready), 1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mr_no_done", int'(bus.done), 0);
            chk("mr_idle", int'(bus.cmd_ready), 1);
            chk("mr_wop_idle", int'(bus.write_op), 0);
            step();
        end
        bus.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
